scpad_rd_rsp_gather: RTL and testbench

Responder-side return path of the scratchpad crossbar read protocol.
- Frontend/backend read requests carry a per-lane bank select (shift_mask_t) and a lane enable (enable_mask_t); the slot_mask_t goes to the SRAM banks elsewhere.
- This block records each accepted request's metadata and waits the fixed SRAM read latency.
- It then gathers the bank outputs into logical lane order, zeroes disabled lanes, and buffers the result for a valid/ready consumer (TCA / VReg controller side).

---
 rtl/scpad_rd_rsp_gather_pkg.sv | 34 +++
 rtl/scpad_rd_rsp_gather_if.sv | 44 ++++
 rtl/scpad_lane_gather.sv | 20 ++
 rtl/scpad_rd_rsp_gather.sv | 124 ++++++++++++
 tb/tb_scpad_rd_rsp_gather.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scpad_rd_rsp_gather_pkg.sv
// Shared types for the scratchpad read-response return path: lane/bank
// geometry, request metadata and the buffered response record.
package scpad_rd_rsp_gather_pkg;

  localparam int NUM_COLS        = 32;
  localparam int ELEM_W          = 16;
  localparam int BANK_IDX_W      = $clog2(NUM_COLS);
  localparam int DRAM_ID_WIDTH   = 8;
  localparam int SCPAD_RSP_DEPTH = 4;

  typedef logic [NUM_COLS-1:0][BANK_IDX_W-1:0] shift_mask_t;
  typedef logic [NUM_COLS-1:0]                 enable_mask_t;
  typedef logic [NUM_COLS-1:0]                 slot_mask_t;
  typedef logic [NUM_COLS-1:0][ELEM_W-1:0]     scpad_data_t;

  typedef enum logic {
    SRC_FE = 1'b0,
    SRC_BE = 1'b1
  } src_t;

  typedef struct packed {
    shift_mask_t                shift;
    enable_mask_t               en;
    src_t                       src;
    logic [DRAM_ID_WIDTH-1:0]   id;
  } rsp_meta_t;

  typedef struct packed {
    scpad_data_t                data;
    src_t                       src;
    logic [DRAM_ID_WIDTH-1:0]   id;
  } scpad_rsp_t;

endpackage

// File: rtl/scpad_rd_rsp_gather_if.sv
// Request / bank-data / response bundle of the read-response gather block.
// With SCPAD_RSP_LAT_CHK_EN defined the bundle also carries the bank-side
// read-valid strobe and the sticky latency-error flag.
interface scpad_rd_rsp_gather_if;
  import scpad_rd_rsp_gather_pkg::*;

  logic                     req_valid;
  logic                     req_ready;
  shift_mask_t              req_shift;
  enable_mask_t             req_en;
  src_t                     req_src;
  logic [DRAM_ID_WIDTH-1:0] req_id;
  scpad_data_t              bank_rdata;
  logic                     rsp_valid;
  logic                     rsp_ready;
  scpad_data_t              rsp_data;
  src_t                     rsp_src;
  logic [DRAM_ID_WIDTH-1:0] rsp_id;
`ifdef SCPAD_RSP_LAT_CHK_EN
  logic                     bank_rvalid;
  logic                     lat_err;
`endif

  // Requester / bank model side
  modport master (
`ifdef SCPAD_RSP_LAT_CHK_EN
    output bank_rvalid,
    input  lat_err,
`endif
    output req_valid, req_shift, req_en, req_src, req_id, bank_rdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_src, rsp_id
  );

  // Gather block side
  modport slave (
`ifdef SCPAD_RSP_LAT_CHK_EN
    input  bank_rvalid,
    output lat_err,
`endif
    input  req_valid, req_shift, req_en, req_src, req_id, bank_rdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_src, rsp_id
  );

endinterface

// File: rtl/scpad_lane_gather.sv
// Combinational per-lane crossbar: each logical lane picks the bank named by
// its shift entry, disabled lanes read as zero. Shared with the write path.
module scpad_lane_gather
  import scpad_rd_rsp_gather_pkg::*;
(
  input  shift_mask_t  shift,
  input  enable_mask_t en,
  input  scpad_data_t  rdata,
  output scpad_data_t  data
);

  // Lane i = en[i] ? rdata[shift[i]] : 0; duplicate shifts broadcast one bank
  always_comb begin
    data = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (en[i]) data[i] = rdata[shift[i]];
    end
  end

endmodule

// File: rtl/scpad_rd_rsp_gather.sv
// Scratchpad read-response gather: tracks accepted read requests through the
// fixed SRAM latency, reorders bank outputs into lane order and buffers the
// rows for a valid/ready consumer. Optional SCPAD_RSP_LAT_CHK_EN adds a
// sticky check that the banks' read-valid matches the expected return cycle.
module scpad_rd_rsp_gather
  import scpad_rd_rsp_gather_pkg::*;
#(
  parameter int SRAM_LAT = 2,
  parameter int DEPTH    = SCPAD_RSP_DEPTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  scpad_rd_rsp_gather_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic             accept;
  logic             pop;
  logic             push;
  logic [CNT_W-1:0] cnt;

  logic             vld_p  [SRAM_LAT];
  rsp_meta_t        meta_p [SRAM_LAT];
  rsp_meta_t        meta_f;
  scpad_data_t      gath_data;

  scpad_rsp_t       mem [DEPTH];
  scpad_rsp_t       head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fcnt;
  logic             empty;
  logic             full;

  assign accept = bus.req_valid & bus.req_ready;
  assign pop    = bus.rsp_valid & bus.rsp_ready;

  // Credits cover both in-flight reads and buffered rows, so the FIFO never overflows
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (accept && !pop) begin
      cnt <= cnt + 1'b1;
    end else if (!accept && pop) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign bus.req_ready = (cnt < DEPTH_C);

  // ---- stage 0: request accepted, SRAM read issued ----
  // Valid bits walk the fixed read latency; no stall is ever needed
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SRAM_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < SRAM_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Metadata rides next to its valid bit; only meaningful where valid is set
  always_ff @(posedge CLK) begin
    meta_p[0] <= '{shift: bus.req_shift, en: bus.req_en, src: bus.req_src, id: bus.req_id};
    for (int i = 1; i < SRAM_LAT; i++) meta_p[i] <= meta_p[i-1];
  end

  // ---- final stage: bank data valid, gather and push ----
  assign push   = vld_p[SRAM_LAT-1];
  assign meta_f = meta_p[SRAM_LAT-1];

  scpad_lane_gather u_gather (
    .shift (meta_f.shift),
    .en    (meta_f.en),
    .rdata (bus.bank_rdata),
    .data  (gath_data)
  );

  // FIFO pointers and occupancy; push and pop may coincide at any fill level
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fcnt <= fcnt + 1'b1;
      else if (!push && pop) fcnt <= fcnt - 1'b1;
    end
  end

  // Row storage; bank_rdata is captured only in the final-stage cycle
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{data: gath_data, src: meta_f.src, id: meta_f.id};
  end

  // ---- output: FIFO head, forced to zero when empty ----
  assign empty = (fcnt == '0);
  assign full  = (fcnt == DEPTH_C);
  assign head  = mem[rd_ptr];

  assign bus.rsp_valid = !empty;
  assign bus.rsp_data  = empty ? '0     : head.data;
  assign bus.rsp_src   = empty ? SRC_FE : head.src;
  assign bus.rsp_id    = empty ? '0     : head.id;

  a_no_overflow: assert property (@(posedge CLK) disable iff (RST) !(push && full && !pop));

`ifdef SCPAD_RSP_LAT_CHK_EN
  // Sticky flag: banks returned data in a cycle other than the tracked one
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.lat_err <= 1'b0;
    end else if (bus.bank_rvalid != push) begin
      bus.lat_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_scpad_rd_rsp_gather.sv
// Directed bench for scpad_rd_rsp_gather: table of gather vectors plus
// sequences for back-pressure, streaming, simultaneous accept/pop and reset.
module tb_scpad_rd_rsp_gather;
  import scpad_rd_rsp_gather_pkg::*;

  localparam int LAT = 2;
  localparam int DEP = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  scpad_rd_rsp_gather_if bus();

  scpad_rd_rsp_gather #(.SRAM_LAT(LAT), .DEPTH(DEP)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    shift_mask_t  shift;
    enable_mask_t en;
    src_t         src;
    logic [7:0]   id;
    scpad_data_t  rdata;
    scpad_data_t  exp;
  } vec_t;

  vec_t        vecs [4];
  scpad_rsp_t  sb [$];
  scpad_rsp_t  cur_exp;
  scpad_data_t rdata_by_id [256];
  logic        pv  [LAT];
  logic [7:0]  pid [LAT];
  int          mcnt;
  int          n_pass = 0;
  int          n_chk  = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive_req(input logic [7:0] id, input src_t src, input shift_mask_t sh,
                           input enable_mask_t en, input scpad_data_t rd, input scpad_data_t ex);
    bus.req_id    = id;
    bus.req_src   = src;
    bus.req_shift = sh;
    bus.req_en    = en;
    rdata_by_id[id] = rd;
    cur_exp = '{data: ex, src: src, id: id};
  endtask

  // Identity shift, all lanes on, bank b returns {id, b}
  task automatic drive_pat(input logic [7:0] id);
    shift_mask_t sh;
    scpad_data_t rd;
    for (int i = 0; i < NUM_COLS; i++) begin
      sh[i] = BANK_IDX_W'(i);
      rd[i] = {id, 8'(i)};
    end
    drive_req(id, id[0] ? SRC_BE : SRC_FE, sh, '1, rd, rd);
  endtask

  // One clock: check outputs against scoreboard, advance, drive the bank model
  task automatic cycle();
    logic       acc, pp;
    logic [7:0] idc;
    check("req_ready", 512'(bus.req_ready), 512'(mcnt < DEP));
    if (bus.rsp_valid) begin
      if (sb.size() == 0) check("rsp_spurious", 512'(1'b1), 512'(1'b0));
      else begin
        check("rsp_data", 512'(bus.rsp_data), 512'(sb[0].data));
        check("rsp_src",  512'(bus.rsp_src),  512'(sb[0].src));
        check("rsp_id",   512'(bus.rsp_id),   512'(sb[0].id));
      end
    end
    acc = bus.req_valid && bus.req_ready;
    pp  = bus.rsp_valid && bus.rsp_ready;
    idc = bus.req_id;
    @(posedge CLK);
    @(negedge CLK);
    if (acc) begin
      sb.push_back(cur_exp);
      mcnt++;
    end
    if (pp && sb.size() > 0) begin
      void'(sb.pop_front());
      mcnt--;
    end
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i]  = pv[i-1];
      pid[i] = pid[i-1];
    end
    pv[0]  = acc;
    pid[0] = idc;
    bus.bank_rdata = pv[LAT-1] ? rdata_by_id[pid[LAT-1]] : {NUM_COLS{16'hDEAD}};
`ifdef SCPAD_RSP_LAT_CHK_EN
    bus.bank_rvalid = pv[LAT-1];
`endif
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_ready"}, 512'(bus.req_ready), 512'(1'b1));
    check({pfx, "_valid"}, 512'(bus.rsp_valid), 512'(1'b0));
    check({pfx, "_data"},  512'(bus.rsp_data),  512'(0));
    check({pfx, "_src"},   512'(bus.rsp_src),   512'(SRC_FE));
    check({pfx, "_id"},    512'(bus.rsp_id),    512'(0));
  endtask

  task automatic clear_model();
    sb.delete();
    mcnt = 0;
    for (int i = 0; i < LAT; i++) begin
      pv[i]  = 1'b0;
      pid[i] = '0;
    end
    bus.bank_rdata = {NUM_COLS{16'hDEAD}};
`ifdef SCPAD_RSP_LAT_CHK_EN
    bus.bank_rvalid = 1'b0;
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, first, run, gap;

    // Vector table: hand-derived gather results
    for (int i = 0; i < NUM_COLS; i++) begin
      vecs[0].shift[i] = BANK_IDX_W'(i);
      vecs[0].rdata[i] = 16'(16'h1000 + i);
      vecs[0].exp[i]   = 16'(16'h1000 + i);
      vecs[1].shift[i] = BANK_IDX_W'(31 - i);
      vecs[1].rdata[i] = 16'(16'h2000 + i);
      vecs[1].exp[i]   = (i < 16) ? 16'(16'h2000 + 31 - i) : 16'h0;
      vecs[2].shift[i] = BANK_IDX_W'(5);
      vecs[2].rdata[i] = 16'(16'h3000 + i);
      vecs[2].exp[i]   = (i % 2 == 0) ? 16'h3005 : 16'h0;
      vecs[3].shift[i] = BANK_IDX_W'((i + 7) % 32);
      vecs[3].rdata[i] = 16'(16'hA000 + i * 17);
      vecs[3].exp[i]   = ((i % 8) >= 4) ? 16'(16'hA000 + ((i + 7) % 32) * 17) : 16'h0;
    end
    vecs[0].en = 32'hFFFF_FFFF; vecs[0].src = SRC_FE; vecs[0].id = 8'd1;
    vecs[1].en = 32'h0000_FFFF; vecs[1].src = SRC_BE; vecs[1].id = 8'd2;
    vecs[2].en = 32'h5555_5555; vecs[2].src = SRC_BE; vecs[2].id = 8'd3;
    vecs[3].en = 32'hF0F0_F0F0; vecs[3].src = SRC_FE; vecs[3].id = 8'd4;

    bus.req_valid = 1'b0;
    bus.req_shift = '0;
    bus.req_en    = '0;
    bus.req_src   = SRC_FE;
    bus.req_id    = '0;
    bus.rsp_ready = 1'b0;
    clear_model();
    cur_exp = '0;

    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check_reset("reset");

    // Single isolated requests from the table
    for (int v = 0; v < 4; v++) begin
      drive_req(vecs[v].id, vecs[v].src, vecs[v].shift, vecs[v].en, vecs[v].rdata, vecs[v].exp);
      bus.req_valid = 1'b1;
      bus.rsp_ready = 1'b1;
      cycle();
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 10) begin
        cycle();
        lat++;
      end
      check("vec_latency", 512'(lat), 512'(3));
      check("vec_data", 512'(bus.rsp_data), 512'(vecs[v].exp));
      check("vec_src",  512'(bus.rsp_src),  512'(vecs[v].src));
      check("vec_id",   512'(bus.rsp_id),   512'(vecs[v].id));
      cycle();
      check("vec_empty_data", 512'(bus.rsp_data), 512'(0));
    end

    // Back-pressure: five offered, four accepted, then drained in order
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_pat(8'(k));
      bus.req_valid = 1'b1;
      check("bp_ready", 512'(bus.req_ready), 512'(k < 4));
      cycle();
    end
    bus.req_valid = 1'b0;
    repeat (3) cycle();
    check("bp_held_valid", 512'(bus.rsp_valid), 512'(1'b1));
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("bp_order_valid", 512'(bus.rsp_valid), 512'(1'b1));
      check("bp_order_id", 512'(bus.rsp_id), 512'(k));
      cycle();
    end
    check("bp_drained", 512'(bus.rsp_valid), 512'(1'b0));
    check("bp_ready_back", 512'(bus.req_ready), 512'(1'b1));

    // Streaming: one response per cycle, no gaps
    first = -1; run = 0; gap = 0;
    for (int c = 0; c < 30; c++) begin
      if (c < 16) begin
        drive_pat(8'(16 + c));
        bus.req_valid = 1'b1;
      end else begin
        bus.req_valid = 1'b0;
      end
      if (bus.rsp_valid) begin
        if (first < 0) first = c;
        if (gap == 0) run++;
      end else if (first >= 0) begin
        gap = 1;
      end
      cycle();
    end
    check("stream_first", 512'(first), 512'(3));
    check("stream_run", 512'(run), 512'(16));
    check("stream_drained", 512'(sb.size()), 512'(0));

    // Simultaneous accept and pop at DEPTH-1, then at full
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_pat(8'(40 + k));
      bus.req_valid = 1'b1;
      cycle();
    end
    bus.req_valid = 1'b0;
    repeat (3) cycle();
    drive_pat(8'd43);
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    cycle();
    check("same_cnt3_ready", 512'(bus.req_ready), 512'(1'b1));
    drive_pat(8'd44);
    bus.rsp_ready = 1'b0;
    cycle();
    check("full_ready", 512'(bus.req_ready), 512'(1'b0));
    drive_pat(8'd45);
    bus.rsp_ready = 1'b1;
    cycle();
    check("full_pop_ready", 512'(bus.req_ready), 512'(1'b1));
    cycle();
    bus.req_valid = 1'b0;
    repeat (10) cycle();
    check("same_no_loss", 512'(sb.size()), 512'(0));
    check("same_drained", 512'(bus.rsp_valid), 512'(1'b0));

    // Reset with two buffered and two in flight
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_pat(8'(50 + k));
      bus.req_valid = 1'b1;
      cycle();
    end
    bus.req_valid = 1'b0;
    check("pre_rst_valid", 512'(bus.rsp_valid), 512'(1'b1));
    RST = 1'b1;
    #1;
    check("rst_async_valid", 512'(bus.rsp_valid), 512'(1'b0));
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    clear_model();
    check_reset("midrst");
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.bank_rdata = rdata_by_id[52];
      @(posedge CLK);
      @(negedge CLK);
      check("post_rst_no_rsp", 512'(bus.rsp_valid), 512'(1'b0));
    end
    check("post_rst_ready", 512'(bus.req_ready), 512'(1'b1));
    bus.bank_rdata = {NUM_COLS{16'hDEAD}};

`ifdef SCPAD_RSP_LAT_CHK_EN
    check("lat_err_clean", 512'(bus.lat_err), 512'(1'b0));
    drive_pat(8'd60);
    bus.req_valid = 1'b1;
    cycle();
    bus.req_valid = 1'b0;
    repeat (5) cycle();
    check("lat_err_ontime", 512'(bus.lat_err), 512'(1'b0));
    bus.bank_rvalid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.bank_rvalid = 1'b0;
    check("lat_err_set", 512'(bus.lat_err), 512'(1'b1));
    repeat (2) cycle();
    check("lat_err_sticky", 512'(bus.lat_err), 512'(1'b1));
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    clear_model();
    check("lat_err_cleared", 512'(bus.lat_err), 512'(1'b0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
